filter_pad_streamer: RTL and testbench
======================================

FILTER_PAD_STREAMER -- requirements
Module: filter_pad_streamer

Interface
REQ-001 Parameter width, default 320, active pixels per image row.
REQ-002 Parameter height, default 240, active rows per image.
REQ-003 Parameter kernel_size, default 3, odd; boundary width BW = (kernel_size-1)/2.
REQ-004 Parameter fifo_depth, default 4, power of two; prefetch buffer entries.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 iStart  input  1  one-cycle pulse; begins one frame when idle.
REQ-008 iBaseAddr  input  32  word address of pixel (0,0); sampled on accepted iStart.
REQ-009 oReq  output  1  memory read request strobe, one pixel per request.
REQ-010 oRdAddress  output  32  read word address, valid while oReq=1.
REQ-011 iRdValid  input  1  read data return strobe; returns arrive in request order.
REQ-012 iRdData  input  24  returned pixel, {R,G,B} 8 bits each.
REQ-013 oValid  output  1  output pixel strobe to the filter's iValid.
REQ-014 oData  output  24  output pixel, {R,G,B}.
REQ-015 oBusy  output  1  high from accepted iStart until oDone.
REQ-016 oDone  output  1  one-cycle pulse after the last padded pixel of the frame.

Function
REQ-017 The block SHALL emit each padded row as RW = width+2*BW beats: BW zero beats, then width image beats, then BW zero beats.
REQ-018 The frame SHALL be BW top zero rows, then height image rows, then BW bottom zero rows, plus the flush row of REQ-034 when enabled.
REQ-019 States SHALL be IDLE, TOP, LEFT, PIX, RIGHT, BOT, FIN; IDLE->TOP on iStart; TOP->LEFT after BW rows; LEFT->PIX after BW beats; PIX->RIGHT after width beats; RIGHT->LEFT on a non-final image row, RIGHT->BOT after image row height-1; BOT->FIN after its last row; FIN->IDLE in one cycle with oDone=1.
REQ-020 In TOP, LEFT, RIGHT and BOT the block SHALL assert oValid=1 with oData=0 every cycle.
REQ-021 In PIX the block SHALL assert oValid=1 only when the prefetch FIFO is non-empty, popping one entry per beat; an empty FIFO SHALL stall PIX with oValid=0 and no counter movement.
REQ-022 A read request SHALL issue only when outstanding+occupancy < fifo_depth and requested pixels < width*height; addresses SHALL be iBaseAddr, iBaseAddr+1, ... in raster order.
REQ-023 Prefetch SHALL start at the first TOP cycle, so image pixels can be fetched while top and left padding are emitted.
REQ-024 iRdValid SHALL push iRdData into the FIFO in the same cycle; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-025 An iRdValid with no outstanding request SHALL be ignored.
REQ-026 iStart SHALL be ignored while oBusy=1.
REQ-027 oData/oValid SHALL be registered; the first oValid SHALL follow the accepted iStart by exactly 1 cycle.
REQ-028 Column and row counters SHALL be 16 bits; the request and address counters SHALL be 32 bits, with address wrap modulo 2^32.

Reset
REQ-029 On reset assertion the block SHALL enter IDLE immediately, regardless of clock.
REQ-030 On reset assertion oReq, oValid, oBusy and oDone SHALL go to 0, and oData and oRdAddress SHALL go to 0.
REQ-031 On reset assertion the FIFO, the outstanding count and all counters SHALL clear.
REQ-032 Reset mid-frame SHALL abandon the frame with no oDone pulse.
REQ-033 Read returns arriving after reset deassertion SHALL be discarded until the next iStart.

Configuration
REQ-034 With macro FILTER_PAD_FLUSH_ROW_EN defined, the block SHALL append one extra zero row of RW beats after the BW bottom rows, to drain the filter pipeline.
REQ-035 With FILTER_PAD_FLUSH_ROW_EN undefined, the frame SHALL end after the BW bottom rows.

Structure
REQ-036 A shared package SHALL hold the state encoding, the pixel width (24) and the BW/RW derivation functions.
REQ-037 The prefetch buffer SHALL be the sub-module filter_pad_fifo: synchronous, fifo_depth x 24, with push, pop, empty and count.

Verification
REQ-038 width=4, height=3, kernel_size=3, flush enabled, read latency 2, iStart -> 36 oValid beats with rows 0, 4 and 5 all zero, image beats at columns 1..4, oDone exactly once.
REQ-039 Same stimulus with flush disabled -> 30 oValid beats, oDone 1 cycle after the 30th beat.
REQ-040 Memory returns pixel value = address, base 0x100 -> image beats in row 1 carry 0x000100..0x000103, and row 3 ends with 0x00010B.
REQ-041 Read latency 10 cycles -> PIX stalls with oValid=0, no pixel is lost or duplicated, and outstanding requests never exceed 4.
REQ-042 Reset asserted mid-PIX then new iStart -> outputs 0 during reset, stale returns dropped, and the new frame matches REQ-038 exactly.
REQ-043 iStart pulsed while oBusy=1 -> ignored, and exactly one frame is emitted.

Source files
------------

// File: rtl/filter_pad_streamer_pkg.sv
// filter_pad_streamer_pkg
// Shared definitions for the padded-frame streamer: sequencer state encoding,
// pixel width and the padding geometry helpers (boundary width, padded row width).
package filter_pad_streamer_pkg;

  localparam int PIX_W = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TOP   = 3'd1,
    LEFT  = 3'd2,
    PIX   = 3'd3,
    RIGHT = 3'd4,
    BOT   = 3'd5,
    FIN   = 3'd6
  } state_t;

  // Boundary width: number of zero pixels/rows needed on each side of the image.
  function automatic int calc_bw(input int k);
    return (k - 1) / 2;
  endfunction

  // Padded row width in beats.
  function automatic int calc_rw(input int w, input int k);
    return w + 2 * calc_bw(k);
  endfunction

endpackage

// File: rtl/filter_pad_fifo.sv
// filter_pad_fifo
// Small synchronous prefetch buffer with show-ahead read data: dout always
// presents the oldest entry, pop consumes it. Depth must be a power of two
// (at least 2). Pushes into a full buffer and pops from an empty one are dropped.
module filter_pad_fifo
  import filter_pad_streamer_pkg::*;
#(
  parameter int depth  = 4,
  parameter int data_w = PIX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [data_w-1:0]        din,
  output logic [data_w-1:0]        dout,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [data_w-1:0] mem [depth];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/filter_pad_streamer.sv
// filter_pad_streamer
// Streams one zero-padded image frame into a convolution filter. Pixels are
// prefetched from word-addressed memory into filter_pad_fifo while the top and
// left padding beats are being emitted.
// Build option: FILTER_PAD_FLUSH_ROW_EN appends one extra zero row after the
// bottom padding so the downstream filter pipeline drains.
// kernel_size must be at least 3 (the first beat of a frame is a top pad beat).
//
// state | meaning
// IDLE  | waiting for iStart, outputs quiet
// TOP   | next beat is a zero beat of the top padding rows
// LEFT  | next beat is a left-border zero beat of an image row
// PIX   | next beat is an image pixel popped from the prefetch FIFO (stalls if empty)
// RIGHT | next beat is a right-border zero beat of an image row
// BOT   | next beat is a zero beat of the bottom (and optional flush) rows
// FIN   | last beat sent; pulse oDone and return to IDLE
module filter_pad_streamer
  import filter_pad_streamer_pkg::*;
#(
  parameter int width       = 320,
  parameter int height      = 240,
  parameter int kernel_size = 3,
  parameter int fifo_depth  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iStart,
  input  logic [31:0]      iBaseAddr,
  output logic             oReq,
  output logic [31:0]      oRdAddress,
  input  logic             iRdValid,
  input  logic [PIX_W-1:0] iRdData,
  output logic             oValid,
  output logic [PIX_W-1:0] oData,
  output logic             oBusy,
  output logic             oDone
);

  localparam int BW = calc_bw(kernel_size);
  localparam int RW = calc_rw(width, kernel_size);
`ifdef FILTER_PAD_FLUSH_ROW_EN
  localparam int FLUSH_ROWS = 1;
`else
  localparam int FLUSH_ROWS = 0;
`endif
  localparam int CW = $clog2(fifo_depth) + 1;

  localparam logic [15:0] RW_LAST  = 16'(RW - 1);
  localparam logic [15:0] BW_LAST  = 16'(BW - 1);
  localparam logic [15:0] W_LAST   = 16'(width - 1);
  localparam logic [15:0] H_LAST   = 16'(height - 1);
  localparam logic [15:0] BOT_LAST = 16'(BW + FLUSH_ROWS - 1);
  localparam logic [31:0] PIX_TOTAL = 32'(width * height);
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(fifo_depth);

  state_t            state;
  logic [15:0]       col;
  logic [15:0]       row;
  logic [31:0]       rd_addr;
  logic [31:0]       req_cnt;
  logic [CW-1:0]     outstanding;
  logic [CW:0]       inflight;
  logic              ret_ok;
  logic              start_ok;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [PIX_W-1:0]  fifo_head;

  // A return with nothing outstanding is stale (e.g. from before a reset) and is dropped.
  assign ret_ok     = iRdValid && (outstanding != '0);
  assign start_ok   = (state == IDLE) && iStart;
  assign inflight   = {1'b0, outstanding} + {1'b0, fifo_count};
  assign oReq       = oBusy && (req_cnt < PIX_TOTAL) && (inflight < DEPTH_LIM);
  assign oRdAddress = rd_addr;
  assign fifo_pop   = (state == PIX) && !fifo_empty;

  filter_pad_fifo #(
    .depth  (fifo_depth),
    .data_w (PIX_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ret_ok),
    .pop   (fifo_pop),
    .din   (iRdData),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Prefetch: raster-order addresses and outstanding-request bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr     <= '0;
      req_cnt     <= '0;
      outstanding <= '0;
    end else begin
      if (start_ok) begin
        rd_addr <= iBaseAddr;
        req_cnt <= '0;
      end else if (oReq) begin
        rd_addr <= rd_addr + 32'd1;
        req_cnt <= req_cnt + 32'd1;
      end
      case ({oReq, ret_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Frame sequencer: registers the beat for the current position, then advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      col    <= '0;
      row    <= '0;
      oValid <= 1'b0;
      oData  <= '0;
      oBusy  <= 1'b0;
      oDone  <= 1'b0;
    end else begin
      oValid <= 1'b0;
      oData  <= '0;
      oDone  <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            // First top pad beat goes out with the acceptance edge itself.
            state  <= TOP;
            oBusy  <= 1'b1;
            oValid <= 1'b1;
            col    <= 16'd1;
            row    <= '0;
          end
        end
        TOP: begin
          oValid <= 1'b1;
          if (col == RW_LAST) begin
            col <= '0;
            if (row == BW_LAST) begin
              row   <= '0;
              state <= LEFT;
            end else begin
              row <= row + 16'd1;
            end
          end else begin
            col <= col + 16'd1;
          end
        end
        LEFT: begin
          oValid <= 1'b1;
          if (col == BW_LAST) begin
            col   <= '0;
            state <= PIX;
          end else begin
            col <= col + 16'd1;
          end
        end
        PIX: begin
          if (!fifo_empty) begin
            oValid <= 1'b1;
            oData  <= fifo_head;
            if (col == W_LAST) begin
              col   <= '0;
              state <= RIGHT;
            end else begin
              col <= col + 16'd1;
            end
          end
        end
        RIGHT: begin
          oValid <= 1'b1;
          if (col == BW_LAST) begin
            col <= '0;
            if (row == H_LAST) begin
              row   <= '0;
              state <= BOT;
            end else begin
              row   <= row + 16'd1;
              state <= LEFT;
            end
          end else begin
            col <= col + 16'd1;
          end
        end
        BOT: begin
          oValid <= 1'b1;
          if (col == RW_LAST) begin
            col <= '0;
            if (row == BOT_LAST) begin
              row   <= '0;
              state <= FIN;
            end else begin
              row <= row + 16'd1;
            end
          end else begin
            col <= col + 16'd1;
          end
        end
        FIN: begin
          oDone <= 1'b1;
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_pad_streamer.sv
// tb_filter_pad_streamer
// Self-checking bench: table of frame scenarios with hand-computed spot values,
// reset/restart corner sequences, then randomized frames with random latency and
// spurious return strobes. Expected beats come from a padded-image model.
module tb_filter_pad_streamer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int K  = 3;
  localparam int D  = 4;
  localparam int BW = (K - 1) / 2;
  localparam int RW = W + 2 * BW;
`ifdef FILTER_PAD_FLUSH_ROW_EN
  localparam int FLUSH = 1;
  localparam int EXP_BEATS = 36;
`else
  localparam int FLUSH = 0;
  localparam int EXP_BEATS = 30;
`endif
  localparam int N_ROWS = H + 2 * BW + FLUSH;

  logic        clk = 1'b0;
  logic        reset;
  logic        iStart;
  logic [31:0] iBaseAddr;
  logic        oReq;
  logic [31:0] oRdAddress;
  logic        iRdValid;
  logic [23:0] iRdData;
  logic        oValid;
  logic [23:0] oData;
  logic        oBusy;
  logic        oDone;

  filter_pad_streamer #(
    .width(W), .height(H), .kernel_size(K), .fifo_depth(D)
  ) dut (
    .clk(clk), .reset(reset), .iStart(iStart), .iBaseAddr(iBaseAddr),
    .oReq(oReq), .oRdAddress(oRdAddress), .iRdValid(iRdValid), .iRdData(iRdData),
    .oValid(oValid), .oData(oData), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct { int due; logic [31:0] addr; } rd_t;
  rd_t         pend[$];
  int          last_due = 0;
  int          lat_cfg = 2;
  bit          lat_rand = 0;
  bit          spurious = 0;
  bit          rd_real = 0;
  logic [31:0] data_mask = 32'h0;
  int          req_total = 0;
  int          ret_total = 0;
  int          max_out = 0;

  logic [23:0] cap_data[$];
  int          cap_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [23:0] exp_q[$];

  function automatic logic [23:0] mem_val(input logic [31:0] a, input logic [31:0] m);
    return a[23:0] ^ m[23:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: in-order returns, per-request latency, optional stray strobes.
  always @(posedge clk) begin
    rd_t e;
    int  lat;
    cyc++;
    if (iRdValid && rd_real) ret_total++;
    if (oReq) begin
      req_total++;
      lat = lat_rand ? int'($urandom_range(1, 12)) : lat_cfg;
      e.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      e.addr = oRdAddress;
      last_due = e.due;
      pend.push_back(e);
    end
    #1;
    iRdValid = 1'b0;
    iRdData  = 24'h0;
    rd_real  = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
      e = pend.pop_front();
      iRdValid = 1'b1;
      iRdData  = mem_val(e.addr, data_mask);
      rd_real  = 1'b1;
    end else if (spurious && pend.size() == 0 && $urandom_range(0, 3) == 0) begin
      iRdValid = 1'b1;
      iRdData  = 24'hBADBAD;
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (oValid) begin
      cap_data.push_back(oData);
      cap_cyc.push_back(cyc);
    end
    if (oDone) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (req_total - ret_total > max_out) max_out = req_total - ret_total;
  end

  // Reference: full padded frame, pixel (r,c) of the image lives at base + r*W + c.
  task automatic build_expected(input logic [31:0] base, input logic [31:0] mask);
    exp_q.delete();
    for (int r = 0; r < N_ROWS; r++) begin
      for (int c = 0; c < RW; c++) begin
        if (r >= BW && r < BW + H && c >= BW && c < BW + W)
          exp_q.push_back(mem_val(base + 32'((r - BW) * W + (c - BW)), mask));
        else
          exp_q.push_back(24'h0);
      end
    end
  endtask

  task automatic run_frame(input string name, input logic [31:0] base, input logic [31:0] mask,
                           input int restart_at, output int first_cyc, output int last_cyc);
    int start_cyc;
    int req0;
    int waited;
    build_expected(base, mask);
    cap_data.delete();
    cap_cyc.delete();
    done_cnt  = 0;
    data_mask = mask;
    max_out   = 0;
    req0      = req_total;
    @(posedge clk); #1;
    iBaseAddr = base;
    iStart    = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    iStart    = 1'b0;
    iBaseAddr = 32'hDEADBEEF;
    check({name, " busy_on_start"}, oBusy, 1);
    waited = 0;
    while (done_cnt == 0 && waited < 3000) begin
      @(posedge clk); #1;
      waited++;
      if (restart_at > 0 && waited == restart_at) begin
        iStart    = 1'b1;
        iBaseAddr = base + 32'h40;
      end else begin
        iStart = 1'b0;
      end
    end
    iStart = 1'b0;
    check({name, " done_seen"}, done_cnt != 0, 1);
    repeat (12) @(posedge clk);
    #1;
    check({name, " done_once"}, done_cnt, 1);
    check({name, " beat_count"}, cap_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_data.size(); i++)
      check($sformatf("%s beat%0d", name, i), cap_data[i], exp_q[i]);
    first_cyc = 0;
    last_cyc  = 0;
    if (cap_cyc.size() > 0) begin
      first_cyc = cap_cyc[0];
      last_cyc  = cap_cyc[cap_cyc.size() - 1];
      check({name, " first_valid_latency"}, first_cyc - start_cyc, 1);
      check({name, " done_after_last"}, done_cyc - last_cyc, 1);
    end
    check({name, " outstanding_le_4"}, max_out <= D, 1);
    check({name, " request_count"}, req_total - req0, W * H);
    check({name, " busy_after_done"}, oBusy, 0);
  endtask

  typedef struct {
    string       name;
    int          lat;
    logic [31:0] base;
    int          restart_at;
    int          exp_beats;
    logic [23:0] exp_r1_first;
    logic [23:0] exp_r3_last;
    bit          exp_stall;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int fc;
    int lc;
    int waited;
    int n_at;
    reset     = 1'b1;
    iStart    = 1'b0;
    iBaseAddr = 32'h0;
    iRdValid  = 1'b0;
    iRdData   = 24'h0;

    tbl[0] = '{"lat2_b100",   2,  32'h0000_0100, 0,  EXP_BEATS, 24'h000100, 24'h00010B, 1'b0};
    tbl[1] = '{"lat10_b100",  10, 32'h0000_0100, 0,  EXP_BEATS, 24'h000100, 24'h00010B, 1'b1};
    tbl[2] = '{"lat1_wrap",   1,  32'hFFFF_FFFE, 0,  EXP_BEATS, 24'hFFFFFE, 24'h000009, 1'b0};
    tbl[3] = '{"lat5_restart",5,  32'h0000_2000, 12, EXP_BEATS, 24'h002000, 24'h00200B, 1'b0};
    tbl[4] = '{"lat3_babcdef",3,  32'h00AB_CDEF, 0,  EXP_BEATS, 24'hABCDEF, 24'hABCDFA, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset oValid", oValid, 0);
    check("reset oReq", oReq, 0);
    check("reset oBusy", oBusy, 0);
    check("reset oDone", oDone, 0);
    check("reset oData", oData, 0);
    check("reset oRdAddress", oRdAddress, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle oBusy", oBusy, 0);
    check("idle oReq", oReq, 0);

    for (int t = 0; t < 5; t++) begin
      lat_cfg  = tbl[t].lat;
      lat_rand = 1'b0;
      spurious = 1'b0;
      run_frame(tbl[t].name, tbl[t].base, 32'h0, tbl[t].restart_at, fc, lc);
      check({tbl[t].name, " tbl_beats"}, cap_data.size(), tbl[t].exp_beats);
      check({tbl[t].name, " row1_first_pix"},
            (cap_data.size() > RW + 1) ? cap_data[RW + 1] : 24'hxxxxxx, tbl[t].exp_r1_first);
      check({tbl[t].name, " row3_last_pix"},
            (cap_data.size() > 3 * RW + 4) ? cap_data[3 * RW + 4] : 24'hxxxxxx, tbl[t].exp_r3_last);
      if (tbl[t].exp_stall)
        check({tbl[t].name, " pix_stalled"}, (lc - fc + 1) > cap_data.size(), 1);
    end

    // Reset in the middle of the image region, with slow returns still in flight.
    lat_cfg  = 10;
    lat_rand = 1'b0;
    spurious = 1'b0;
    data_mask = 32'h0;
    cap_data.delete();
    cap_cyc.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    iBaseAddr = 32'h100;
    iStart    = 1'b1;
    @(posedge clk); #1;
    iStart    = 1'b0;
    waited = 0;
    while (cap_data.size() < 9 && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    check("midpix reached", cap_data.size() >= 9, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async rst oValid", oValid, 0);
    check("async rst oReq", oReq, 0);
    check("async rst oBusy", oBusy, 0);
    check("async rst oData", oData, 0);
    check("async rst oRdAddress", oRdAddress, 0);
    n_at = cap_data.size();
    repeat (3) @(posedge clk);
    #1;
    check("held rst oValid", oValid, 0);
    check("held rst oDone", oDone, 0);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("post rst no done", done_cnt, 0);
    check("post rst no beats", cap_data.size(), n_at);
    check("post rst busy", oBusy, 0);
    check("stale returns drained", pend.size(), 0);
    lat_cfg = 2;
    run_frame("after_reset", 32'h100, 32'h0, 0, fc, lc);
    check("after_reset row3_last_pix",
          (cap_data.size() > 3 * RW + 4) ? cap_data[3 * RW + 4] : 24'hxxxxxx, 24'h00010B);

    // Randomized frames: random base, data pattern, latency and stray strobes.
    for (int f = 0; f < 6; f++) begin
      lat_rand = 1'b1;
      spurious = 1'b1;
      run_frame($sformatf("rand%0d", f), $urandom, $urandom, 0, fc, lc);
    end
    lat_rand = 1'b0;
    spurious = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

endmodule
